// File: rtl/sine_phase_to_amp.sv
// DDS phase-to-sine converter: quarter-wave LUT with quadrant folding,
// linear interpolation, and a 4-clock pipeline after phase intake.
module sine_phase_to_amp #(
    parameter int PHASE_W = 14,
    parameter int AMP_W   = 16,
    parameter int LUT_A   = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic [PHASE_W-1:0]       phase,
    output logic signed [AMP_W-1:0]  amp,
    output logic                     amp_valid
);

    localparam int F  = PHASE_W - 2;
    localparam int S  = F - LUT_A;
    localparam int FW = 6;
    localparam int PW = AMP_W + FW;

    function automatic logic [AMP_W-1:0] lut_f(input logic [6:0] k);
        case (k)
            7'd0:  lut_f = 16'd0;
            7'd1:  lut_f = 16'd804;
            7'd2:  lut_f = 16'd1608;
            7'd3:  lut_f = 16'd2410;
            7'd4:  lut_f = 16'd3212;
            7'd5:  lut_f = 16'd4011;
            7'd6:  lut_f = 16'd4808;
            7'd7:  lut_f = 16'd5602;
            7'd8:  lut_f = 16'd6393;
            7'd9:  lut_f = 16'd7179;
            7'd10: lut_f = 16'd7962;
            7'd11: lut_f = 16'd8739;
            7'd12: lut_f = 16'd9512;
            7'd13: lut_f = 16'd10278;
            7'd14: lut_f = 16'd11039;
            7'd15: lut_f = 16'd11793;
            7'd16: lut_f = 16'd12539;
            7'd17: lut_f = 16'd13279;
            7'd18: lut_f = 16'd14010;
            7'd19: lut_f = 16'd14732;
            7'd20: lut_f = 16'd15446;
            7'd21: lut_f = 16'd16151;
            7'd22: lut_f = 16'd16846;
            7'd23: lut_f = 16'd17530;
            7'd24: lut_f = 16'd18204;
            7'd25: lut_f = 16'd18868;
            7'd26: lut_f = 16'd19519;
            7'd27: lut_f = 16'd20159;
            7'd28: lut_f = 16'd20787;
            7'd29: lut_f = 16'd21403;
            7'd30: lut_f = 16'd22005;
            7'd31: lut_f = 16'd22594;
            7'd32: lut_f = 16'd23170;
            7'd33: lut_f = 16'd23731;
            7'd34: lut_f = 16'd24279;
            7'd35: lut_f = 16'd24811;
            7'd36: lut_f = 16'd25329;
            7'd37: lut_f = 16'd25832;
            7'd38: lut_f = 16'd26319;
            7'd39: lut_f = 16'd26790;
            7'd40: lut_f = 16'd27245;
            7'd41: lut_f = 16'd27683;
            7'd42: lut_f = 16'd28105;
            7'd43: lut_f = 16'd28510;
            7'd44: lut_f = 16'd28898;
            7'd45: lut_f = 16'd29268;
            7'd46: lut_f = 16'd29621;
            7'd47: lut_f = 16'd29956;
            7'd48: lut_f = 16'd30273;
            7'd49: lut_f = 16'd30571;
            7'd50: lut_f = 16'd30852;
            7'd51: lut_f = 16'd31113;
            7'd52: lut_f = 16'd31356;
            7'd53: lut_f = 16'd31580;
            7'd54: lut_f = 16'd31785;
            7'd55: lut_f = 16'd31971;
            7'd56: lut_f = 16'd32137;
            7'd57: lut_f = 16'd32285;
            7'd58: lut_f = 16'd32412;
            7'd59: lut_f = 16'd32521;
            7'd60: lut_f = 16'd32609;
            7'd61: lut_f = 16'd32678;
            7'd62: lut_f = 16'd32728;
            7'd63: lut_f = 16'd32757;
            default: lut_f = 16'd32767;
        endcase
    endfunction

    logic [PHASE_W-1:0] ph_q, ph_d;
    logic               v0_q, v0_d;
    logic               neg1_q, neg1_d;
    logic [6:0]         idx1_q, idx1_d;
    logic [FW-1:0]      frac1_q, frac1_d;
    logic               v1_q, v1_d;
    logic               neg2_q, neg2_d;
    logic [AMP_W-1:0]   lo2_q, lo2_d;
    logic [AMP_W-1:0]   hi2_q, hi2_d;
    logic [FW-1:0]      frac2_q, frac2_d;
    logic               v2_q, v2_d;
    logic               neg3_q, neg3_d;
    logic [AMP_W-1:0]   mag3_q, mag3_d;
    logic               v3_q, v3_d;
    logic [AMP_W-1:0]   amp_q, amp_d;
    logic               amp_valid_q, amp_valid_d;

    logic [1:0]         quad;
    logic [F-1:0]       off;
    logic [F:0]         off_f;
    logic [FW-1:0]      frac;
    logic [6:0]         idx_hi;
    logic [AMP_W-1:0]   diff;
    logic [PW-1:0]      prod;

    assign quad  = ph_q[PHASE_W-1 -: 2];
    assign off   = ph_q[F-1:0];
    // Odd quadrants mirror the offset so the LUT only covers 0..pi/2
    assign off_f = quad[0] ? ({1'b1, {F{1'b0}}} - {1'b0, off}) : {1'b0, off};

    generate
        if (S >= FW) begin : g_frac_trunc
            assign frac = off_f[S-1 -: FW];
        end else begin : g_frac_pad
            assign frac = {off_f[S-1:0], {(FW-S){1'b0}}};
        end
    endgenerate

    assign idx_hi = (idx1_q == 7'd64) ? 7'd64 : idx1_q + 7'd1;
    assign diff   = hi2_q - lo2_q;
    assign prod   = {{FW{1'b0}}, diff} * {{AMP_W{1'b0}}, frac2_q}
                  + PW'(32);

    always_comb begin
        ph_d        = ph_q;
        v0_d        = ce;
        neg1_d      = neg1_q;
        idx1_d      = idx1_q;
        frac1_d     = frac1_q;
        v1_d        = v0_q;
        neg2_d      = neg2_q;
        lo2_d       = lo2_q;
        hi2_d       = hi2_q;
        frac2_d     = frac2_q;
        v2_d        = v1_q;
        neg3_d      = neg3_q;
        mag3_d      = mag3_q;
        v3_d        = v2_q;
        amp_d       = amp_q;
        amp_valid_d = v3_q;
        if (ce) begin
            ph_d = phase;
        end
        if (v0_q) begin
            neg1_d  = quad[1];
            idx1_d  = off_f[F:S];
            frac1_d = frac;
        end
        if (v1_q) begin
            neg2_d  = neg1_q;
            lo2_d   = lut_f(idx1_q);
            hi2_d   = lut_f(idx_hi);
            frac2_d = frac1_q;
        end
        if (v2_q) begin
            neg3_d = neg2_q;
            mag3_d = lo2_q + prod[PW-1:FW];
        end
        if (v3_q) begin
            amp_d = neg3_q ? ({AMP_W{1'b0}} - mag3_q) : mag3_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q        <= '0;
            v0_q        <= 1'b0;
            neg1_q      <= 1'b0;
            idx1_q      <= '0;
            frac1_q     <= '0;
            v1_q        <= 1'b0;
            neg2_q      <= 1'b0;
            lo2_q       <= '0;
            hi2_q       <= '0;
            frac2_q     <= '0;
            v2_q        <= 1'b0;
            neg3_q      <= 1'b0;
            mag3_q      <= '0;
            v3_q        <= 1'b0;
            amp_q       <= '0;
            amp_valid_q <= 1'b0;
        end else begin
            ph_q        <= ph_d;
            v0_q        <= v0_d;
            neg1_q      <= neg1_d;
            idx1_q      <= idx1_d;
            frac1_q     <= frac1_d;
            v1_q        <= v1_d;
            neg2_q      <= neg2_d;
            lo2_q       <= lo2_d;
            hi2_q       <= hi2_d;
            frac2_q     <= frac2_d;
            v2_q        <= v2_d;
            neg3_q      <= neg3_d;
            mag3_q      <= mag3_d;
            v3_q        <= v3_d;
            amp_q       <= amp_d;
            amp_valid_q <= amp_valid_d;
        end
    end

    assign amp       = amp_q;
    assign amp_valid = amp_valid_q;

endmodule

// File: tb/tb_sine_phase_to_amp.sv
// Directed bench for sine_phase_to_amp: table vectors, full sweep,
// gapped strobes and mid-flight reset.
module tb_sine_phase_to_amp;

    logic               clk;
    logic               rst_n;
    logic               ce;
    logic [13:0]        phase;
    logic signed [15:0] amp;
    logic               amp_valid;

    int checks;
    int failures;

    sine_phase_to_amp #(
        .PHASE_W(14),
        .AMP_W  (16),
        .LUT_A  (6)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .phase    (phase),
        .amp      (amp),
        .amp_valid(amp_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] ph;
        int          exp;
        string       nm;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm,
                       input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic run_vec(input logic [13:0] ph, input int exp,
                           input string nm);
        int k;
        ce    = 1'b1;
        phase = ph;
        k     = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) ce = 1'b0;
        end while (!amp_valid && k < 10);
        chk({nm, "_lat"}, k, 5);
        chk(nm, amp, exp);
        @(negedge clk);
        chk({nm, "_pulse"}, {31'd0, amp_valid}, 0);
        chk({nm, "_hold"}, amp, exp);
    endtask

    int  got_s[256];
    int  n;
    real pi;
    real model;
    real err;

    bit  pat[12];
    int  gph[6];
    int  gexp[6];
    int  vh[20];
    int  ah[20];
    int  sidx[20];
    int  s;
    int  cur_exp;

    initial begin
        checks   = 0;
        failures = 0;
        pi       = 3.14159265358979;

        vecs[0]  = '{14'h0400, 12539, "q0_mid"};
        vecs[1]  = '{14'h1400, 30273, "q1_mid"};
        vecs[2]  = '{14'h2400, -12539, "q2_mid"};
        vecs[3]  = '{14'h3400, -30273, "q3_mid"};
        vecs[4]  = '{14'h0000, 0, "b_zero"};
        vecs[5]  = '{14'h1000, 32767, "b_peak"};
        vecs[6]  = '{14'h2000, 0, "b_half"};
        vecs[7]  = '{14'h3000, -32767, "b_trough"};
        vecs[8]  = '{14'h3FFF, -13, "b_wrap"};
        vecs[9]  = '{14'h0041, 817, "interp_1"};
        vecs[10] = '{14'h0020, 402, "interp_half"};
        vecs[11] = '{14'h1FFF, 13, "q1_end"};
        vecs[12] = '{14'h0FFF, 32767, "q0_end"};
        vecs[13] = '{14'h1C30, 11980, "interp_q1"};
        vecs[14] = '{14'h0000, 0, "wrap_zero"};

        rst_n = 1'b0;
        ce    = 1'b0;
        phase = 14'h0400;

        for (int i = 0; i < 6; i++) begin
            ce = i[0];
            @(negedge clk);
            chk("rst_amp", amp, 0);
            chk("rst_valid", {31'd0, amp_valid}, 0);
        end
        rst_n = 1'b1;
        ce    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_valid", {31'd0, amp_valid}, 0);
            chk("idle_amp", amp, 0);
        end

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i].ph, vecs[i].exp, vecs[i].nm);
        end

        n = 0;
        for (int t = 0; t < 264; t++) begin
            @(negedge clk);
            if (amp_valid) begin
                if (n < 256) got_s[n] = amp;
                n++;
            end
            if (t < 256) begin
                ce    = 1'b1;
                phase = 14'(t * 64);
            end else begin
                ce = 1'b0;
            end
        end
        chk("sweep_cnt", n, 256);
        for (int k = 0; k < 256; k++) begin
            model = 32767.0 * $sin(2.0 * pi * real'(k * 64) / 16384.0);
            err   = real'(got_s[k]) - model;
            if (err < 0.0) err = -err;
            checks++;
            if (err > 2.0) begin
                failures++;
                $display("FAIL sweep_%0d got=%0d model=%0f", k, got_s[k], model);
            end
        end
        for (int k = 0; k < 128; k++) begin
            chk("antisym", got_s[k], -got_s[k + 128]);
        end

        pat     = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 1, 1, 0};
        gph     = '{32'h0400, 32'h1400, 32'h2400, 32'h3400, 32'h1000, 32'h3000};
        gexp    = '{12539, 30273, -12539, -30273, 32767, -32767};
        cur_exp = -804;
        s       = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            vh[t]   = {31'd0, amp_valid};
            ah[t]   = amp;
            sidx[t] = s;
            if (t < 12 && pat[t]) begin
                ce    = 1'b1;
                phase = 14'(gph[s]);
                s++;
            end else begin
                ce = 1'b0;
            end
        end
        for (int t = 0; t < 20; t++) begin
            if (t >= 5 && t - 5 < 12 && pat[t - 5]) begin
                cur_exp = gexp[sidx[t - 5]];
                chk("gap_valid", vh[t], 1);
                chk("gap_amp", ah[t], cur_exp);
            end else begin
                chk("gap_novalid", vh[t], 0);
                chk("gap_hold", ah[t], cur_exp);
            end
        end

        @(negedge clk);
        ce    = 1'b1;
        phase = 14'h1000;
        @(negedge clk);
        phase = 14'h1400;
        @(negedge clk);
        phase = 14'h3000;
        @(negedge clk);
        ce    = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_amp", amp, 0);
        chk("midrst_valid", {31'd0, amp_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_valid", {31'd0, amp_valid}, 0);
            chk("post_rst_amp", amp, 0);
        end
        run_vec(14'h0400, 12539, "post_rst_new");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
